// File: rtl/horizontal_counter.sv
// Pixel-rate horizontal timing for 640x480@60 VGA: pixel divider, pixel counter, region FSM.
// Define HCOUNT_PIXEL_DIV_EN to divide clk by PIX_DIV; otherwise one pixel per enabled clk.
module horizontal_counter #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned PIX_DIV   = 4,
    parameter logic        HSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        pix_tick,
    output logic [15:0] H_counter,
    output logic        ena_V,
    output logic        hsync,
    output logic        h_active
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [15:0] A_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] F_LAST  = 16'(H_ACTIVE + H_FP - 1);
    localparam logic [15:0] S_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 || PIX_DIV == 0
        || H_TOTAL > 65536) begin : g_bad_params
        $error("horizontal_counter: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    logic        tick_c;
    logic [15:0] h_cnt_q;
    logic [15:0] h_cnt_d;
    region_e     state_q;
    logic        hsync_q;
    logic        h_active_q;

`ifdef HCOUNT_PIXEL_DIV_EN
    localparam int unsigned   DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Divider holds its phase while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (enable) begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_c = rst_n & enable & (div_cnt_q == DIV_LAST);
`else
    assign tick_c = rst_n & enable;
`endif

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
        end else if (tick_c) begin
            h_cnt_q <= h_cnt_d;
        end
    end

    // Region FSM; hsync/h_active are registered alongside the state so they track H_counter exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACTIVE;
            hsync_q    <= ~HSYNC_POL;
            h_active_q <= 1'b1;
        end else if (tick_c) begin
            case (state_q)
                ACTIVE: begin
                    if (h_cnt_q == A_LAST) begin
                        state_q    <= FRONT;
                        h_active_q <= 1'b0;
                    end
                end
                FRONT: begin
                    if (h_cnt_q == F_LAST) begin
                        state_q <= SYNC;
                        hsync_q <= HSYNC_POL;
                    end
                end
                SYNC: begin
                    if (h_cnt_q == S_LAST) begin
                        state_q <= BACK;
                        hsync_q <= ~HSYNC_POL;
                    end
                end
                BACK: begin
                    if (h_cnt_q == H_LAST) begin
                        state_q    <= ACTIVE;
                        h_active_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ACTIVE;
                    hsync_q    <= ~HSYNC_POL;
                    h_active_q <= 1'b1;
                end
            endcase
        end
    end

    assign pix_tick  = tick_c;
    assign ena_V     = tick_c & (h_cnt_q == H_LAST);
    assign H_counter = h_cnt_q;
    assign hsync     = hsync_q;
    assign h_active  = h_active_q;

endmodule

// File: tb/tb_horizontal_counter.sv
// Bench for horizontal_counter: per-cycle comparison against a counter/region model plus pinned checks.
module tb_horizontal_counter;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned PIX_DIV  = 4;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
`ifdef HCOUNT_PIXEL_DIV_EN
    localparam bit DIV_ON   = 1'b1;
    localparam int LINE_CLK = 3200;
    localparam int FIRST_N  = 3;
    localparam int RESUME_N = 4;
`else
    localparam bit DIV_ON   = 1'b0;
    localparam int LINE_CLK = 800;
    localparam int FIRST_N  = 0;
    localparam int RESUME_N = 1;
`endif
    localparam int CLK_PER_PIX = DIV_ON ? int'(PIX_DIV) : 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pix_tick;
    logic [15:0] H_counter;
    logic        ena_V;
    logic        hsync;
    logic        h_active;

    int checks = 0;
    int errors = 0;
    int m_div = 0;
    int m_h = 0;

    horizontal_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .PIX_DIV  (PIX_DIV),
        .HSYNC_POL(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .pix_tick (pix_tick),
        .H_counter(H_counter),
        .ena_V    (ena_V),
        .hsync    (hsync),
        .h_active (h_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tick();
        return rst_n && enable && (!DIV_ON || m_div == int'(PIX_DIV) - 1);
    endfunction

    // Model: pixel position advances once per PIX_DIV enabled clocks (or every enabled clock).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 0;
            m_h   <= 0;
        end else if (enable) begin
            if (!DIV_ON || m_div == int'(PIX_DIV) - 1) m_h <= (m_h + 1) % int'(H_TOTAL);
            if (DIV_ON) m_div <= (m_div + 1) % int'(PIX_DIV);
        end
    end

    // Outputs follow from the pixel position: sync window and visible window by plain range tests.
    always @(negedge clk) begin
        chk("pix_tick", 32'(pix_tick), 32'(model_tick()));
        chk("ena_V", 32'(ena_V), 32'(model_tick() && m_h == int'(H_TOTAL) - 1));
        chk("H_counter", 32'(H_counter), 32'(m_h));
        chk("hsync", 32'(hsync),
            32'((m_h >= int'(H_ACTIVE + H_FP) && m_h < int'(H_ACTIVE + H_FP + H_SYNC)) ? 0 : 1));
        chk("h_active", 32'(h_active), 32'(m_h < int'(H_ACTIVE)));
    end

    task automatic wait_h(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (H_counter != 16'(target) && n < budget);
        chk("wait_H", 32'(H_counter), 32'(target));
    endtask

    initial begin
        int n;
        int first_ev;
        int last_ev;
        int ev_cnt;
        int sync_cnt;
        int act_cnt;

        // Reset state, held with enable high to confirm reset dominates.
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_H", 32'(H_counter), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_h_active", 32'(h_active), 32'd1);
        chk("rst_pix_tick", 32'(pix_tick), 32'd0);
        chk("rst_ena_V", 32'(ena_V), 32'd0);

        // First tick after release follows the divider count.
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pix_tick || n >= 20) break;
            n++;
        end
        chk("first_tick_clk", 32'(n), 32'(FIRST_N));
        @(posedge clk);
        #1 chk("first_tick_H", 32'(H_counter), 32'd1);

        // Two full lines aligned on a wrap: strobe spacing, sync and active widths.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ena_V && n < 4000);
        chk("line_wrap_seen", 32'(ena_V), 32'd1);
        chk("ena_V_at_H", 32'(H_counter), 32'd799);
        ev_cnt = 0; sync_cnt = 0; act_cnt = 0; first_ev = -1; last_ev = -1;
        for (int i = 0; i < 2 * LINE_CLK; i++) begin
            @(negedge clk);
            if (ena_V) begin
                ev_cnt++;
                if (first_ev < 0) first_ev = i;
                last_ev = i;
            end
            if (!hsync) sync_cnt++;
            if (h_active) act_cnt++;
        end
        chk("ena_V_count", 32'(ev_cnt), 32'd2);
        chk("ena_V_spacing", 32'(last_ev - first_ev), 32'(LINE_CLK));
        chk("hsync_low_clk", 32'(sync_cnt), 32'(2 * 96 * CLK_PER_PIX));
        chk("h_active_clk", 32'(act_cnt), 32'(2 * 640 * CLK_PER_PIX));

        // Enable low for 50 clk at H=300: everything freezes, resumes from held divider phase.
        wait_h(300, 4000);
        #1 enable = 1'b0;
        ev_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (pix_tick || ena_V || H_counter != 16'd300) ev_cnt++;
        end
        chk("hold_violations", 32'(ev_cnt), 32'd0);
        chk("hold_H", 32'(H_counter), 32'd300);
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (H_counter != 16'd301 && n < 20);
        chk("resume_clk", 32'(n), 32'(RESUME_N));

        // Random enable pattern checked cycle by cycle.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1 enable = ($urandom_range(0, 7) != 0);
        end
        @(posedge clk);
        #1 enable = 1'b1;

        // Asynchronous reset in the sync region.
        wait_h(700, 8000);
        chk("sync_at_700", 32'(hsync), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_H", 32'(H_counter), 32'd0);
        chk("async_hsync", 32'(hsync), 32'd1);
        chk("async_h_active", 32'(h_active), 32'd1);
        chk("async_ena_V", 32'(ena_V), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("restart_H", 32'(H_counter), 32'(300 / CLK_PER_PIX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
